// File: rtl/kernel_loader_pkg.sv
// ----------------------------------------------------------------------------
// kernel_loader_pkg : shared FSM encodings and default weight width
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package kernel_loader_pkg;

  localparam int KER_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/kernel_loader_tap_decode.sv
// ----------------------------------------------------------------------------
// tap_decode : turns a tap index plus a strobe into a one-hot tap select
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tap_decode #(
  parameter int NB    = 9,
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             strobe,
  output logic [NB-1:0]    onehot
);

  for (genvar gi = 0; gi < NB; gi++) begin : g_tap
    localparam logic [IDX_W-1:0] TAP = IDX_W'(gi);
    assign onehot[gi] = strobe & (idx == TAP);
  end

endmodule

`default_nettype wire

// File: rtl/kernel_loader.sv
// ----------------------------------------------------------------------------
// kernel_loader : streams KER_NB signed weights onto a shared tap-config bus.
// Optional KERNEL_LOADER_LAST_EN adds up_last framing and the sticky cfg_err.
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module kernel_loader
  import kernel_loader_pkg::*;
#(
  parameter int KER_WIDTH = KER_WIDTH_DEF,
  parameter int KER_NB    = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KER_WIDTH-1:0] up_ker,
  input  logic                 up_val,
  output logic                 up_rdy,
`ifdef KERNEL_LOADER_LAST_EN
  input  logic                 up_last,
  output logic                 cfg_err,
`endif
  output logic [KER_WIDTH-1:0] cfg_ker,
  output logic [KER_NB-1:0]    cfg_val,
  output logic                 busy,
  output logic                 cfg_done
);

  localparam int                IDX_W    = $clog2(KER_NB);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(KER_NB - 1);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   up_rdy_q, up_rdy_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [KER_WIDTH-1:0]   cfg_ker_q, cfg_ker_d;
  logic [KER_NB-1:0]      cfg_val_q, cfg_val_d;
  logic                   xfer;
  logic [KER_NB-1:0]      tap_hot;
`ifdef KERNEL_LOADER_LAST_EN
  logic                   err_q, err_d;
`endif

  // up_rdy_q is high exactly while in LOAD, so it doubles as the state qualifier
  assign xfer = up_val & up_rdy_q;

  tap_decode #(
    .NB    (KER_NB),
    .IDX_W (IDX_W)
  ) u_tap_decode (
    .idx    (idx_q),
    .strobe (xfer),
    .onehot (tap_hot)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    cfg_val_d = tap_hot;
    cfg_ker_d = xfer ? up_ker : '0;
`ifdef KERNEL_LOADER_LAST_EN
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
`ifdef KERNEL_LOADER_LAST_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
`ifdef KERNEL_LOADER_LAST_EN
            if (!up_last) err_d = 1'b1;
`endif
          end
`ifdef KERNEL_LOADER_LAST_EN
          else if (up_last) begin
            // early last: the weight is still strobed, but the kernel is abandoned
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
`endif
          else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    up_rdy_d = (state_d == ST_LOAD);
    busy_d   = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      up_rdy_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_ker_q <= '0;
      cfg_val_q <= '0;
`ifdef KERNEL_LOADER_LAST_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      up_rdy_q  <= up_rdy_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_ker_q <= cfg_ker_d;
      cfg_val_q <= cfg_val_d;
`ifdef KERNEL_LOADER_LAST_EN
      err_q     <= err_d;
`endif
    end
  end

  assign up_rdy   = up_rdy_q;
  assign busy     = busy_q;
  assign cfg_done = done_q;
  assign cfg_ker  = cfg_ker_q;
  assign cfg_val  = cfg_val_q;
`ifdef KERNEL_LOADER_LAST_EN
  assign cfg_err  = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_kernel_loader.sv
// ----------------------------------------------------------------------------
// tb_kernel_loader : scoreboard bench for kernel_loader with KER_NB=4
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_kernel_loader;

  localparam int KW = 16;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          up_val = 1'b0;
  logic [KW-1:0] up_ker = '0;
  logic          up_rdy;
  logic [KW-1:0] cfg_ker;
  logic [NB-1:0] cfg_val;
  logic          busy;
  logic          cfg_done;
`ifdef KERNEL_LOADER_LAST_EN
  logic          up_last = 1'b0;
  logic          cfg_err;
`endif

  kernel_loader #(
    .KER_WIDTH (KW),
    .KER_NB    (NB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .up_ker   (up_ker),
    .up_val   (up_val),
    .up_rdy   (up_rdy),
`ifdef KERNEL_LOADER_LAST_EN
    .up_last  (up_last),
    .cfg_err  (cfg_err),
`endif
    .cfg_ker  (cfg_ker),
    .cfg_val  (cfg_val),
    .busy     (busy),
    .cfg_done (cfg_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NB-1:0] val;
    logic [KW-1:0] ker;
    logic          done;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   strobe_cnt = 0;
  int   done_cnt = 0;
  int   m_state = 0;
  int   m_idx = 0;
  logic m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: predicts each strobe at the edge its transfer happens
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      m_state = 0;
      m_idx   = 0;
      m_err   = 1'b0;
    end else begin
      case (m_state)
        0: if (start) begin
             m_state = 1;
             m_idx   = 0;
             m_err   = 1'b0;
           end
        1: if (up_val) begin
             e.val        = '0;
             e.val[m_idx] = 1'b1;
             e.ker        = up_ker;
             e.done       = (m_idx == NB - 1);
             sb_q.push_back(e);
             if (m_idx == NB - 1) begin
               m_state = 2;
`ifdef KERNEL_LOADER_LAST_EN
               if (!up_last) m_err = 1'b1;
`endif
             end
`ifdef KERNEL_LOADER_LAST_EN
             else if (up_last) begin
               m_state = 0;
               m_err   = 1'b1;
             end
`endif
             else begin
               m_idx++;
             end
           end
        default: m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("cfg_val", 32'(cfg_val), 32'(e.val));
      check("cfg_ker", 32'(cfg_ker), 32'(e.ker));
      check("cfg_done", 32'(cfg_done), 32'(e.done));
    end else begin
      check("cfg_val_idle", 32'(cfg_val), 32'd0);
      check("cfg_ker_idle", 32'(cfg_ker), 32'd0);
      check("cfg_done_idle", 32'(cfg_done), 32'd0);
    end
    check("up_rdy", 32'(up_rdy), 32'(m_state == 1));
    check("busy", 32'(busy), 32'(m_state == 1));
`ifdef KERNEL_LOADER_LAST_EN
    check("cfg_err", 32'(cfg_err), 32'(m_err));
`endif
    if (cfg_val != '0) strobe_cnt++;
    if (cfg_done) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send(input logic [KW-1:0] w, input logic last, input int gap);
    logic seen;
    int   t;
    seen   = 1'b0;
    t      = 0;
    up_val = 1'b1;
    up_ker = w;
`ifdef KERNEL_LOADER_LAST_EN
    up_last = last;
`endif
    while (!seen && t < 50) begin
      @(negedge clk);
      seen = up_rdy;
      @(posedge clk);
      #1;
      t++;
    end
    if (!seen) check("xfer_timeout", 32'd0, 32'd1);
    up_val = 1'b0;
    up_ker = 16'hA5A5;  // junk on the bus while idle must never reach cfg_ker
`ifdef KERNEL_LOADER_LAST_EN
    up_last = 1'b0;
`endif
    tick(gap);
    if (last == 1'b0 && KW == 0) check("unused", 32'd0, 32'd0);
  endtask

  task automatic check_counts(input string tag, input int s0, input int d0,
                              input int exp_s, input int exp_d);
    check({tag, "_strobes"}, 32'(strobe_cnt - s0), 32'(exp_s));
    check({tag, "_dones"}, 32'(done_cnt - d0), 32'(exp_d));
  endtask

  initial begin
    int s0, d0;

    // reset then idle; up_val held high must not be accepted outside LOAD
    tick(6);
    rst    = 1'b0;
    up_val = 1'b1;
    up_ker = 16'h1234;
    tick(4);
    up_val = 1'b0;
    check_counts("idle", 0, 0, 0, 0);

    // continuous load
    s0 = strobe_cnt; d0 = done_cnt;
    do_start();
    send(16'd2, 1'b0, 0);
    send(-16'sd3, 1'b0, 0);
    send(16'd5, 1'b0, 0);
    send(16'd7, 1'b1, 0);
    tick(3);
    check_counts("cont", s0, d0, 4, 1);

    // stalled load, three idle cycles between weights
    s0 = strobe_cnt; d0 = done_cnt;
    do_start();
    for (int i = 1; i <= 4; i++) send(KW'(i), (i == 4), 3);
    tick(2);
    check_counts("stall", s0, d0, 4, 1);

    // abort after two weights; rst wins over start and a pending transfer
    s0 = strobe_cnt; d0 = done_cnt;
    do_start();
    send(16'd10, 1'b0, 0);
    send(16'd11, 1'b0, 0);
    rst = 1'b1; start = 1'b1; up_val = 1'b1;
    tick(1);
    rst = 1'b0; start = 1'b0; up_val = 1'b0;
    tick(3);
    check_counts("abort", s0, d0, 2, 0);
    s0 = strobe_cnt; d0 = done_cnt;
    do_start();
    for (int i = 0; i < 4; i++) send(KW'(16'h0100 + i), (i == 3), 0);
    tick(2);
    check_counts("restart", s0, d0, 4, 1);

    // start pulsed mid-load is ignored
    s0 = strobe_cnt; d0 = done_cnt;
    do_start();
    send(16'd20, 1'b0, 0);
    send(16'd21, 1'b0, 0);
    start = 1'b1;
    send(16'd22, 1'b0, 0);
    start = 1'b0;
    send(16'hFFEC, 1'b1, 0);
    tick(2);
    check_counts("ign_start", s0, d0, 4, 1);

`ifdef KERNEL_LOADER_LAST_EN
    // early last on weight 2 of 4
    s0 = strobe_cnt; d0 = done_cnt;
    do_start();
    send(16'd30, 1'b0, 0);
    send(16'd31, 1'b1, 0);
    tick(5);
    check("err_sticky", 32'(cfg_err), 32'd1);
    check_counts("early_last", s0, d0, 2, 0);
    do_start();
    check("err_cleared", 32'(cfg_err), 32'd0);
    // missing last on the final weight still completes
    s0 = strobe_cnt; d0 = done_cnt;
    for (int i = 0; i < 4; i++) send(KW'(40 + i), 1'b0, 0);
    tick(2);
    check("err_missing_last", 32'(cfg_err), 32'd1);
    check_counts("missing_last", s0, d0, 4, 1);
`endif

    tick(3);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
